top_id: RTL and testbench

Instruction-decode stage of the MIPS pipeline, directly downstream of the instruction-fetch stage. It latches the fetched instruction and PC+1 (IF/ID register), holds the 32×32 register file, sign-extends immediates, and resolves BEQ/BNE in ID. Branch decision and target feed back combinationally to the fetch PC mux. Decoded operands are registered into the ID/EX register, and a debug read port lets the debug unit dump registers over UART.

---
 rtl/top_id.sv | 156 +++++++++++++++
 tb/tb_top_id.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/top_id.sv
// rtl/top_id.sv - MIPS instruction-decode stage: IF/ID latch, register file, branch resolve, ID/EX latch
module top_id #(
  parameter int LONGITUD_INSTRUCCION = 32,
  parameter int CANT_BITS_ADDR       = 10,
  parameter int CANT_REGISTROS       = 32,
  parameter int CANT_BITS_REGISTRO   = 5
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_enable,
  input  logic                            i_stall,
  input  logic                            i_flush,
  input  logic [LONGITUD_INSTRUCCION-1:0] i_instruction,
  input  logic [CANT_BITS_ADDR-1:0]       i_adder_pc,
  input  logic                            i_reg_write_wb,
  input  logic [CANT_BITS_REGISTRO-1:0]   i_reg_addr_wb,
  input  logic [LONGITUD_INSTRUCCION-1:0] i_reg_data_wb,
  input  logic [CANT_BITS_REGISTRO-1:0]   i_debug_addr,
  output logic                            o_branch_taken,
  output logic [CANT_BITS_ADDR-1:0]       o_branch_dir,
  output logic [LONGITUD_INSTRUCCION-1:0] o_dato_rs,
  output logic [LONGITUD_INSTRUCCION-1:0] o_dato_rt,
  output logic [LONGITUD_INSTRUCCION-1:0] o_extension_signo,
  output logic [CANT_BITS_REGISTRO-1:0]   o_rs,
  output logic [CANT_BITS_REGISTRO-1:0]   o_rt,
  output logic [CANT_BITS_REGISTRO-1:0]   o_rd,
  output logic [CANT_BITS_REGISTRO-1:0]   o_shamt,
  output logic [5:0]                      o_opcode,
  output logic [5:0]                      o_funct,
  output logic [CANT_BITS_ADDR-1:0]       o_adder_pc,
  output logic [LONGITUD_INSTRUCCION-1:0] o_debug_dato
);

  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;

  logic [LONGITUD_INSTRUCCION-1:0] ifid_instruction;
  logic [CANT_BITS_ADDR-1:0]       ifid_adder_pc;
  logic [LONGITUD_INSTRUCCION-1:0] regs [CANT_REGISTROS];

  logic [5:0]                      dec_opcode;
  logic [5:0]                      dec_funct;
  logic [CANT_BITS_REGISTRO-1:0]   dec_rs;
  logic [CANT_BITS_REGISTRO-1:0]   dec_rt;
  logic [CANT_BITS_REGISTRO-1:0]   dec_rd;
  logic [CANT_BITS_REGISTRO-1:0]   dec_shamt;
  logic [15:0]                     dec_imm;
  logic [LONGITUD_INSTRUCCION-1:0] dec_ext;
  logic [LONGITUD_INSTRUCCION-1:0] read_rs;
  logic [LONGITUD_INSTRUCCION-1:0] read_rt;
  logic                            wb_active;
  logic                            operands_equal;

  assign dec_opcode = ifid_instruction[31:26];
  assign dec_rs     = ifid_instruction[25:21];
  assign dec_rt     = ifid_instruction[20:16];
  assign dec_rd     = ifid_instruction[15:11];
  assign dec_shamt  = ifid_instruction[10:6];
  assign dec_funct  = ifid_instruction[5:0];
  assign dec_imm    = ifid_instruction[15:0];
  assign dec_ext    = {{(LONGITUD_INSTRUCCION-16){dec_imm[15]}}, dec_imm};

  assign wb_active = i_enable && i_reg_write_wb && (i_reg_addr_wb != '0);

  // Write-first reads so a value retiring this cycle reaches ID without a stall
  always_comb begin
    read_rs = regs[dec_rs];
    read_rt = regs[dec_rt];
    if (wb_active && (i_reg_addr_wb == dec_rs)) read_rs = i_reg_data_wb;
    if (wb_active && (i_reg_addr_wb == dec_rt)) read_rt = i_reg_data_wb;
    if (dec_rs == '0) read_rs = '0;
    if (dec_rt == '0) read_rt = '0;
  end

  assign operands_equal = (read_rs == read_rt);

  always_comb begin
    o_branch_taken = 1'b0;
    if (!i_stall && !i_reset) begin
      if (dec_opcode == OP_BEQ) o_branch_taken = operands_equal;
      if (dec_opcode == OP_BNE) o_branch_taken = !operands_equal;
    end
  end

  // Word-addressed target; the add wraps at the PC width
  assign o_branch_dir = ifid_adder_pc + dec_imm[CANT_BITS_ADDR-1:0];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ifid_instruction <= '0;
      ifid_adder_pc    <= '0;
    end else if (i_enable && !i_stall) begin
      if (i_flush) begin
        ifid_instruction <= '0;
        ifid_adder_pc    <= '0;
      end else begin
        ifid_instruction <= i_instruction;
        ifid_adder_pc    <= i_adder_pc;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < CANT_REGISTROS; i++) regs[i] <= '0;
    end else if (wb_active) begin
      regs[i_reg_addr_wb] <= i_reg_data_wb;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_dato_rs         <= '0;
      o_dato_rt         <= '0;
      o_extension_signo <= '0;
      o_rs              <= '0;
      o_rt              <= '0;
      o_rd              <= '0;
      o_shamt           <= '0;
      o_opcode          <= '0;
      o_funct           <= '0;
      o_adder_pc        <= '0;
    end else if (i_enable) begin
      if (i_stall) begin
        o_dato_rs         <= '0;
        o_dato_rt         <= '0;
        o_extension_signo <= '0;
        o_rs              <= '0;
        o_rt              <= '0;
        o_rd              <= '0;
        o_shamt           <= '0;
        o_opcode          <= '0;
        o_funct           <= '0;
        o_adder_pc        <= '0;
      end else begin
        o_dato_rs         <= read_rs;
        o_dato_rt         <= read_rt;
        o_extension_signo <= dec_ext;
        o_rs              <= dec_rs;
        o_rt              <= dec_rt;
        o_rd              <= dec_rd;
        o_shamt           <= dec_shamt;
        o_opcode          <= dec_opcode;
        o_funct           <= dec_funct;
        o_adder_pc        <= ifid_adder_pc;
      end
    end
  end

  // Debug dump runs even while the pipeline is halted
  always_ff @(posedge i_clock) begin
    if (i_reset) o_debug_dato <= '0;
    else         o_debug_dato <= regs[i_debug_addr];
  end

endmodule

// File: tb/tb_top_id.sv
// tb/tb_top_id.sv - directed self-checking bench for top_id
module tb_top_id;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_instruction;
  logic [9:0]  i_adder_pc;
  logic        i_reg_write_wb;
  logic [4:0]  i_reg_addr_wb;
  logic [31:0] i_reg_data_wb;
  logic [4:0]  i_debug_addr;
  logic        o_branch_taken;
  logic [9:0]  o_branch_dir;
  logic [31:0] o_dato_rs;
  logic [31:0] o_dato_rt;
  logic [31:0] o_extension_signo;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [4:0]  o_shamt;
  logic [5:0]  o_opcode;
  logic [5:0]  o_funct;
  logic [9:0]  o_adder_pc;
  logic [31:0] o_debug_dato;

  int tests  = 0;
  int failed = 0;

  top_id dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_enable          (i_enable),
    .i_stall           (i_stall),
    .i_flush           (i_flush),
    .i_instruction     (i_instruction),
    .i_adder_pc        (i_adder_pc),
    .i_reg_write_wb    (i_reg_write_wb),
    .i_reg_addr_wb     (i_reg_addr_wb),
    .i_reg_data_wb     (i_reg_data_wb),
    .i_debug_addr      (i_debug_addr),
    .o_branch_taken    (o_branch_taken),
    .o_branch_dir      (o_branch_dir),
    .o_dato_rs         (o_dato_rs),
    .o_dato_rt         (o_dato_rt),
    .o_extension_signo (o_extension_signo),
    .o_rs              (o_rs),
    .o_rt              (o_rt),
    .o_rd              (o_rd),
    .o_shamt           (o_shamt),
    .o_opcode          (o_opcode),
    .o_funct           (o_funct),
    .o_adder_pc        (o_adder_pc),
    .o_debug_dato      (o_debug_dato)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic idex_zero(input string tag);
    check({tag, "_opcode"}, {26'd0, o_opcode}, 32'd0);
    check({tag, "_rs"}, {27'd0, o_rs}, 32'd0);
    check({tag, "_ext"}, o_extension_signo, 32'd0);
    check({tag, "_pc"}, {22'd0, o_adder_pc}, 32'd0);
    check({tag, "_dato_rs"}, o_dato_rs, 32'd0);
  endtask

  initial begin
    // Reset with random inputs
    i_reset        = 1'b1;
    i_enable       = 1'($urandom);
    i_stall        = 1'($urandom);
    i_flush        = 1'($urandom);
    i_instruction  = $urandom;
    i_adder_pc     = 10'($urandom);
    i_reg_write_wb = 1'b1;
    i_reg_addr_wb  = 5'($urandom_range(1, 31));
    i_reg_data_wb  = $urandom;
    i_debug_addr   = 5'($urandom);
    step();
    step();
    check("rst_taken", {31'd0, o_branch_taken}, 32'd0);
    check("rst_dir", {22'd0, o_branch_dir}, 32'd0);
    check("rst_dato_rt", o_dato_rt, 32'd0);
    check("rst_rt_rd_shamt", {17'd0, o_rt, o_rd, o_shamt}, 32'd0);
    check("rst_funct", {26'd0, o_funct}, 32'd0);
    check("rst_debug", o_debug_dato, 32'd0);
    idex_zero("rst");

    i_reset        = 1'b0;
    i_enable       = 1'b0;
    i_stall        = 1'b0;
    i_flush        = 1'b0;
    i_instruction  = 32'd0;
    i_adder_pc     = 10'd0;
    i_reg_write_wb = 1'b0;
    for (int k = 1; k < 32; k++) begin
      i_debug_addr = 5'(k);
      step();
      check("rst_reg", o_debug_dato, 32'd0);
    end

    // Write-back and debug read, r0 hard-wired
    i_enable       = 1'b1;
    i_reg_write_wb = 1'b1;
    i_reg_addr_wb  = 5'd5;
    i_reg_data_wb  = 32'h1234_5678;
    step();
    i_reg_write_wb = 1'b0;
    i_debug_addr   = 5'd5;
    step();
    check("dbg_r5", o_debug_dato, 32'h1234_5678);
    i_reg_write_wb = 1'b1;
    i_reg_addr_wb  = 5'd0;
    i_reg_data_wb  = 32'hFFFF_FFFF;
    step();
    i_reg_write_wb = 1'b0;
    i_debug_addr   = 5'd0;
    step();
    check("dbg_r0", o_debug_dato, 32'd0);

    // Same-cycle write-back bypass into ID/EX: add r6, r3, r4
    i_instruction = {6'd0, 5'd3, 5'd4, 5'd6, 5'd0, 6'd32};
    i_adder_pc    = 10'd7;
    step();
    i_instruction  = 32'd0;
    i_reg_write_wb = 1'b1;
    i_reg_addr_wb  = 5'd3;
    i_reg_data_wb  = 32'h0000_00AA;
    step();
    i_reg_write_wb = 1'b0;
    check("byp_dato_rs", o_dato_rs, 32'h0000_00AA);
    check("byp_fields", {17'd0, o_rs, o_rt, o_rd}, {17'd0, 5'd3, 5'd4, 5'd6});
    check("byp_funct", {26'd0, o_funct}, 32'd32);
    check("byp_pc", {22'd0, o_adder_pc}, 32'd7);

    // Branches: r1 = r2 = 7
    i_reg_write_wb = 1'b1;
    i_reg_addr_wb  = 5'd1;
    i_reg_data_wb  = 32'd7;
    step();
    i_reg_addr_wb  = 5'd2;
    step();
    i_reg_write_wb = 1'b0;
    i_instruction  = {6'd4, 5'd1, 5'd2, 16'hFFFE};
    i_adder_pc     = 10'd10;
    step();
    check("beq_taken", {31'd0, o_branch_taken}, 32'd1);
    check("beq_dir", {22'd0, o_branch_dir}, 32'd8);
    i_instruction  = {6'd5, 5'd1, 5'd2, 16'hFFFE};
    step();
    check("beq_ext", o_extension_signo, 32'hFFFF_FFFE);
    check("beq_opcode", {26'd0, o_opcode}, 32'd4);
    check("beq_dato_rt", o_dato_rt, 32'd7);
    check("bne_taken", {31'd0, o_branch_taken}, 32'd0);
    i_instruction  = {6'd5, 5'd1, 5'd3, 16'd2};
    i_adder_pc     = 10'd1023;
    step();
    check("bne_ne_taken", {31'd0, o_branch_taken}, 32'd1);
    check("wrap_dir", {22'd0, o_branch_dir}, 32'd1);

    // Stall: hold IF/ID, bubble ID/EX, suppress branch
    i_stall       = 1'b1;
    i_instruction = 32'h2345_6789;
    i_adder_pc    = 10'd55;
    #1;
    check("stall_taken", {31'd0, o_branch_taken}, 32'd0);
    step();
    idex_zero("stall1");
    step();
    idex_zero("stall2");
    i_flush = 1'b1;
    step();
    idex_zero("stall_flush");
    i_stall = 1'b0;
    i_flush = 1'b0;
    #1;
    check("held_taken", {31'd0, o_branch_taken}, 32'd1);
    check("held_dir", {22'd0, o_branch_dir}, 32'd1);

    // Flush alone: held branch moves to ID/EX, NOP follows it
    i_flush = 1'b1;
    step();
    check("flush_prev_pc", {22'd0, o_adder_pc}, 32'd1023);
    check("flush_prev_op", {26'd0, o_opcode}, 32'd5);
    i_flush       = 1'b0;
    i_instruction = {6'd0, 5'd1, 5'd2, 5'd7, 5'd3, 6'd32};
    i_adder_pc    = 10'd20;
    step();
    idex_zero("flush_nop");

    // Enable low: frozen pipeline and register file, debug still live
    i_enable       = 1'b0;
    i_reg_write_wb = 1'b1;
    i_reg_addr_wb  = 5'd4;
    i_reg_data_wb  = 32'h0000_0055;
    i_instruction  = 32'hFFFF_FFFF;
    i_adder_pc     = 10'd99;
    i_debug_addr   = 5'd4;
    step();
    step();
    check("dis_r4", o_debug_dato, 32'd0);
    idex_zero("dis_idex");
    i_debug_addr = 5'd5;
    step();
    check("dis_dbg_r5", o_debug_dato, 32'h1234_5678);
    i_enable       = 1'b1;
    i_reg_write_wb = 1'b0;
    i_instruction  = 32'd0;
    step();
    check("en_pc", {22'd0, o_adder_pc}, 32'd20);
    check("en_rd_shamt", {22'd0, o_rd, o_shamt}, {22'd0, 5'd7, 5'd3});
    check("en_dato_rs", o_dato_rs, 32'd7);

    // Reset discards an in-flight write-back
    i_reset        = 1'b1;
    i_reg_write_wb = 1'b1;
    i_reg_addr_wb  = 5'd6;
    i_reg_data_wb  = 32'hDEAD_BEEF;
    step();
    i_reset        = 1'b0;
    i_reg_write_wb = 1'b0;
    i_debug_addr   = 5'd6;
    step();
    check("rst_wb_r6", o_debug_dato, 32'd0);
    i_debug_addr   = 5'd5;
    step();
    check("rst_r5", o_debug_dato, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
